// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, CCR flag indices,
// branch condition encodings and CCR sequencer states.
package alu_pkg;

    localparam logic [5:0] ALU_FUN_ADD  = 6'd2;
    localparam logic [5:0] ALU_FUN_SUB  = 6'd3;
    localparam logic [5:0] ALU_FUN_OR   = 6'd5;
    localparam logic [5:0] ALU_FUN_RLC  = 6'd6;
    localparam logic [5:0] ALU_FUN_RRC  = 6'd7;
    localparam logic [5:0] ALU_FUN_SETC = 6'd8;
    localparam logic [5:0] ALU_FUN_CLRC = 6'd9;
    localparam logic [5:0] ALU_FUN_NOT  = 6'd14;
    localparam logic [5:0] ALU_FUN_NEG  = 6'd15;
    localparam logic [5:0] ALU_FUN_INC  = 6'd16;
    localparam logic [5:0] ALU_FUN_DEC  = 6'd17;
    localparam logic [5:0] ALU_FUN_LOOP = 6'd22;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] BR_JZ = 2'd0;
    localparam logic [1:0] BR_JN = 2'd1;
    localparam logic [1:0] BR_JC = 2'd2;
    localparam logic [1:0] BR_JV = 2'd3;

    typedef enum logic [1:0] {
        CCR_RUN     = 2'd0,
        CCR_SAVE    = 2'd1,
        CCR_RESTORE = 2'd2
    } ccr_state_e;

    function automatic logic [3:0] upd_mask(input logic [5:0] fun);
        logic [3:0] m;
        m = 4'b0000;
        case (fun)
            ALU_FUN_ADD, ALU_FUN_SUB:
                m = 4'b1111;
            ALU_FUN_OR, ALU_FUN_NOT, ALU_FUN_NEG,
            ALU_FUN_INC, ALU_FUN_DEC, ALU_FUN_LOOP: begin
                m[FLAG_N] = 1'b1;
                m[FLAG_Z] = 1'b1;
            end
            ALU_FUN_RLC, ALU_FUN_RRC,
            ALU_FUN_SETC, ALU_FUN_CLRC:
                m[FLAG_C] = 1'b1;
            default:
                m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ccr_stack.sv
// Shadow CCR LIFO used to save flags across nested interrupts.
module ccr_stack
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  top_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] lvl_q;

    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lvl_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++)
                if (lvl_q == LW'(i)) mem_q[i] <= din_i;
            lvl_q <= lvl_q + LW'(1);
        end else if (pop_i && !empty_o) begin
            lvl_q <= lvl_q - LW'(1);
        end
    end

    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (lvl_q == LW'(i + 1)) top_o = mem_q[i];
    end

endmodule

// File: rtl/alu_ccr_ctrl.sv
// Condition-code register: flag masking/forwarding, branch
// resolution and interrupt save/restore sequencing.
module alu_ccr_ctrl
    import alu_pkg::*;
#(
    parameter int FUN_W      = 6,
    parameter int FLAG_W     = 4,
    parameter int NEST_DEPTH = 2,
    parameter int LW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [FUN_W-1:0]  alu_fun,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              br_valid,
    input  logic [1:0]        br_cond,
    input  logic              int_req,
    input  logic              rti_req,
    output logic [FLAG_W-1:0] ccr,
    output logic              carry_in,
    output logic              br_taken,
    output logic              int_ack,
    output logic              rti_done,
    output logic              busy,
    output logic [LW-1:0]     nest_lvl
);

    ccr_state_e        state_q, state_d;
    logic [FLAG_W-1:0] ccr_q, ccr_d;
    logic [FLAG_W-1:0] mask, ccr_fwd, clr;
    logic [FLAG_W-1:0] stk_top;
    logic [1:0]        sel;
    logic              run, push, pop;
    logic              stk_full, stk_empty;

    assign run = (state_q == CCR_RUN);

    always_comb begin
        mask = '0;
        if (ex_valid && !stall && run)
            mask = FLAG_W'(upd_mask(alu_fun));
    end

    assign ccr_fwd = (ccr_q & ~mask) | (alu_flags & mask);

    always_comb begin
        sel = 2'(FLAG_Z);
        unique case (br_cond)
            BR_JZ: sel = 2'(FLAG_Z);
            BR_JN: sel = 2'(FLAG_N);
            BR_JC: sel = 2'(FLAG_C);
            BR_JV: sel = 2'(FLAG_V);
        endcase
    end

    assign br_taken = br_valid & ~stall & run & ccr_fwd[sel];
    // a taken branch consumes its flag, overriding any same-cycle set
    assign clr = br_taken ? (FLAG_W'(1) << sel) : '0;

    always_comb begin
        state_d = state_q;
        ccr_d   = ccr_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            CCR_RUN: begin
                if (!stall) begin
                    ccr_d = ccr_fwd & ~clr;
                    if (int_req && !stk_full)
                        state_d = CCR_SAVE;
                    else if (rti_req && !stk_empty)
                        state_d = CCR_RESTORE;
                end
            end
            CCR_SAVE: begin
                push    = 1'b1;
                state_d = CCR_RUN;
            end
            CCR_RESTORE: begin
                pop     = 1'b1;
                ccr_d   = stk_top;
                state_d = CCR_RUN;
            end
            default: state_d = CCR_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CCR_RUN;
            ccr_q   <= '0;
        end else begin
            state_q <= state_d;
            ccr_q   <= ccr_d;
        end
    end

    ccr_stack #(
        .DEPTH (NEST_DEPTH),
        .W     (FLAG_W),
        .LW    (LW)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ccr_q),
        .top_o   (stk_top),
        .level_o (nest_lvl),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign ccr      = ccr_q;
    assign carry_in = ccr_q[FLAG_C];
    // reset masks the sequencer pulses so an aborted save never acks
    assign int_ack  = reset & (state_q == CCR_SAVE);
    assign rti_done = reset & (state_q == CCR_RESTORE);
    assign busy     = reset & (state_q != CCR_RUN);

endmodule

// File: tb/tb_alu_ccr_ctrl.sv
// Randomized and directed checks of alu_ccr_ctrl against a queue-based model.
module tb_alu_ccr_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall, ex_valid, br_valid, int_req, rti_req;
    logic [5:0] alu_fun;
    logic [3:0] alu_flags, ccr;
    logic [1:0] br_cond, nest_lvl;
    logic       carry_in, br_taken, int_ack, rti_done, busy;

    int total = 0;
    int bad   = 0;

    // model: ccr value, stack of saved values, pending one-cycle action
    int        m_ccr;
    int        m_stk[$];
    int        m_act;   // 0 none, 1 saving, 2 restoring
    logic      last_bt;

    always #5 clk = ~clk;

    alu_ccr_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .alu_fun   (alu_fun),
        .alu_flags (alu_flags),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .int_req   (int_req),
        .rti_req   (rti_req),
        .ccr       (ccr),
        .carry_in  (carry_in),
        .br_taken  (br_taken),
        .int_ack   (int_ack),
        .rti_done  (rti_done),
        .busy      (busy),
        .nest_lvl  (nest_lvl)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int flag_mask(input int fun);
        if (fun inside {2, 3}) return 'hF;
        if (fun inside {5, 14, 15, 16, 17, 22}) return 'h3;
        if (fun inside {6, 7, 8, 9}) return 'h4;
        return 0;
    endfunction

    task automatic step(input logic r, input logic st, input logic ev,
                        input logic [5:0] fun, input logic [3:0] fl,
                        input logic bv, input logic [1:0] bc,
                        input logic ir, input logic rr);
        int mk, fwd, e_bt;
        @(negedge clk);
        reset = r; stall = st; ex_valid = ev; alu_fun = fun;
        alu_flags = fl; br_valid = bv; br_cond = bc;
        int_req = ir; rti_req = rr;
        #1;
        mk   = (ev && !st && m_act == 0) ? flag_mask(fun) : 0;
        fwd  = (m_ccr & ~mk) | (int'(fl) & mk);
        e_bt = (m_act == 0 && bv && !st && fwd[bc]) ? 1 : 0;
        chk("ccr", int'(ccr), m_ccr);
        chk("carry_in", int'(carry_in), m_ccr[2]);
        chk("nest_lvl", int'(nest_lvl), m_stk.size());
        chk("busy", int'(busy), (r && m_act != 0) ? 1 : 0);
        chk("int_ack", int'(int_ack), (r && m_act == 1) ? 1 : 0);
        chk("rti_done", int'(rti_done), (r && m_act == 2) ? 1 : 0);
        if (r) chk("br_taken", int'(br_taken), e_bt);
        last_bt = br_taken;
        if (!r) begin
            m_ccr = 0;
            m_stk.delete();
            m_act = 0;
        end else if (m_act == 1) begin
            m_stk.push_back(m_ccr);
            m_act = 0;
        end else if (m_act == 2) begin
            m_ccr = m_stk.pop_back();
            m_act = 0;
        end else if (!st) begin
            m_ccr = e_bt ? (fwd & ~(1 << bc)) : fwd;
            if (ir && m_stk.size() < 2) m_act = 1;
            else if (rr && m_stk.size() > 0) m_act = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [5:0] fun, input logic [3:0] fl);
        step(1, 0, 1, fun, fl, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_ccr = 0; m_act = 0; last_bt = 0;
        reset = 0; stall = 0; ex_valid = 0; alu_fun = 0; alu_flags = 0;
        br_valid = 0; br_cond = 0; int_req = 0; rti_req = 0;
        repeat (2) @(posedge clk);
        #1;

        op(6'd2, 4'b1111);
        chk("pre_reset_ccr", int'(ccr), 'hF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ccr", int'(ccr), 0);
        chk("reset_busy", int'(busy), 0);

        op(6'd2, 4'b1010);
        chk("add_ccr", int'(ccr), 'hA);
        op(6'd5, 4'b0001);
        chk("or_ccr", int'(ccr), 'h9);

        op(6'd3, 4'b0001);
        step(1, 0, 1, 6'd16, 4'b0000, 1, 2'd0, 0, 0);
        chk("jz_fwd_not_taken", int'(last_bt), 0);
        op(6'd3, 4'b0001);
        step(1, 0, 1, 6'd16, 4'b0001, 1, 2'd0, 0, 0);
        chk("jz_fwd_taken", int'(last_bt), 1);
        chk("jz_clear", int'(ccr), 0);

        op(6'd2, 4'b0100);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("int_ack_pulse", int'(int_ack), 1);
        idle();
        chk("int_ack_low", int'(int_ack), 0);
        chk("nest_one", int'(nest_lvl), 1);
        op(6'd9, 4'b0000);
        chk("clrc_ccr", int'(ccr), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rti_done_pulse", int'(rti_done), 1);
        idle();
        chk("rti_ccr", int'(ccr), 'h4);

        op(6'd2, 4'b0001);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0); idle();
        op(6'd2, 4'b0010);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0); idle();
        op(6'd2, 4'b0011);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("full_no_ack", int'(int_ack), 0);
        chk("full_lvl", int'(nest_lvl), 2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1); idle();
        chk("lifo_first", int'(ccr), 'h2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1); idle();
        chk("lifo_second", int'(ccr), 'h1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("empty_rti_ignored", int'(rti_done), 0);
        chk("empty_ccr", int'(ccr), 'h1);

        step(1, 1, 1, 6'd2, 4'b1111, 0, 0, 1, 0);
        chk("stall_ccr", int'(ccr), 'h1);
        chk("stall_busy", int'(busy), 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("abort_lvl", int'(nest_lvl), 0);
        chk("abort_busy", int'(busy), 0);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] f;
            int k;
            k = $urandom_range(0, 9);
            case (k)
                0: f = 6'd2;  1: f = 6'd3;  2: f = 6'd5;
                3: f = 6'd16; 4: f = 6'd6;  5: f = 6'd9;
                6: f = 6'd22; 7: f = 6'd8;  default: f = 6'($urandom);
            endcase
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 5) == 0),
                 1'($urandom), f, 4'($urandom), 1'($urandom),
                 2'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
